// File: rtl/complement_seq_if.sv
// Operand/result handshake bundle for complement_seq.
// slave is the unit side; master is the producer/consumer side.
interface complement_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_ovf
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_ovf
    );
endinterface

// File: rtl/complement_seq.sv
// Chunk-serial two's-complement unit (NEG / ABS / PASS / SM2TC).
// Processes CHUNK bits per cycle, LSB first; a seen-one flag carries the
// ripple between chunks so no full-width carry chain is needed.
//
// state | meaning
// IDLE  | ready for an operand
// BUSY  | one chunk converted per cycle
// DONE  | result held until the consumer takes it
module complement_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input logic             clk,
    input logic             rst,
    complement_seq_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] MODE_NEG   = 2'd0;
    localparam logic [1:0] MODE_ABS   = 2'd1;
    localparam logic [1:0] MODE_SM2TC = 2'd3;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             ovf_req_q;
    logic             seen_q;
    logic             zero_q;
    logic             ovf_q;

    logic             accept;
    logic             last_chunk;
    logic [WIDTH-1:0] x_in;
    logic             neg_in;
    logic             ovf_in;
    logic [CHUNK-1:0] chunk_in;
    logic [CHUNK-1:0] chunk_out;
    logic             seen_run;

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_chunk = (cnt_q == CW'(N - 1));
    assign chunk_in   = x_q[int'(cnt_q) * CHUNK +: CHUNK];

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = BUSY;
            BUSY:    if (last_chunk)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand conditioning at accept: SM2TC strips the sign into the neg
    // decision; overflow is only possible for NEG/ABS of the most negative value.
    always_comb begin
        x_in = bus.in_data;
        if (bus.in_mode == MODE_SM2TC) x_in[WIDTH-1] = 1'b0;
        case (bus.in_mode)
            MODE_NEG: neg_in = 1'b1;
            MODE_ABS: neg_in = bus.in_data[WIDTH-1];
            MODE_SM2TC: neg_in = bus.in_data[WIDTH-1];
            default:  neg_in = 1'b0;
        endcase
        ovf_in = ((bus.in_mode == MODE_NEG) || (bus.in_mode == MODE_ABS)) &&
                 (bus.in_data == MOST_NEG);
    end

    // One chunk of the ripple: each bit flips once a lower one has been seen.
    always_comb begin
        chunk_out = '0;
        seen_run  = seen_q;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_out[i] = neg_q ? (chunk_in[i] ^ seen_run) : chunk_in[i];
            seen_run     = seen_run | chunk_in[i];
        end
    end

    // Datapath registers: latch at accept, fill result chunk by chunk in BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            ovf_req_q <= 1'b0;
            seen_q    <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            x_q       <= x_in;
            neg_q     <= neg_in;
            ovf_req_q <= ovf_in;
            seen_q    <= 1'b0;
            cnt_q     <= '0;
        end else if (state_q == BUSY) begin
            res_q[int'(cnt_q) * CHUNK +: CHUNK] <= chunk_out;
            seen_q <= seen_run;
            cnt_q  <= cnt_q + 1'b1;
            if (last_chunk) begin
                zero_q <= ~seen_run;
                ovf_q  <= ovf_req_q;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = res_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_complement_seq.sv
// Directed and randomized checks of complement_seq across several
// WIDTH/CHUNK configurations.
module tb_complement_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    complement_seq_if #(.WIDTH(64)) if_a ();
    complement_seq_if #(.WIDTH(16)) if_b ();
    complement_seq_if #(.WIDTH(32)) if_c ();
    complement_seq_if #(.WIDTH(16)) if_d ();

    complement_seq #(.WIDTH(64), .CHUNK(8))  dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    complement_seq #(.WIDTH(16), .CHUNK(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    complement_seq #(.WIDTH(32), .CHUNK(32)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    complement_seq #(.WIDTH(16), .CHUNK(1))  dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand to the 64/8 unit, wait for the result, check, consume.
    task automatic run_a(input string tag, input logic [1:0] mode, input logic [63:0] data,
                         input logic [63:0] exp_d, input logic exp_z, input logic exp_o);
        int lat;
        check_val({tag, "_rdy"}, 64'(if_a.in_ready), 64'd1);
        if_a.in_data = data; if_a.in_mode = mode; if_a.in_valid = 1'b1; if_a.out_ready = 1'b0;
        tick();
        if_a.in_valid = 1'b0;
        lat = 0;
        while (!if_a.out_valid && lat < 200) begin tick(); lat++; end
        check_val({tag, "_lat"}, 64'(lat), 64'd8);
        check_val({tag, "_data"}, if_a.out_data, exp_d);
        check_val({tag, "_zero"}, 64'(if_a.out_zero), 64'(exp_z));
        check_val({tag, "_ovf"}, 64'(if_a.out_ovf), 64'(exp_o));
        if_a.out_ready = 1'b1;
        tick();
        if_a.out_ready = 1'b0;
    endtask

    // Same operand to both 16-bit units (CHUNK 4 and CHUNK 1).
    task automatic run_16(input string tag, input logic [1:0] mode, input logic [15:0] data,
                          input logic [15:0] exp_d, input logic exp_z, input logic exp_o);
        int lat_b, lat_d, cyc;
        if_b.in_data = data; if_b.in_mode = mode; if_b.in_valid = 1'b1; if_b.out_ready = 1'b0;
        if_d.in_data = data; if_d.in_mode = mode; if_d.in_valid = 1'b1; if_d.out_ready = 1'b0;
        tick();
        if_b.in_valid = 1'b0; if_d.in_valid = 1'b0;
        lat_b = -1; lat_d = -1; cyc = 0;
        while ((!if_b.out_valid || !if_d.out_valid) && cyc < 100) begin
            tick(); cyc++;
            if (if_b.out_valid && lat_b < 0) lat_b = cyc;
            if (if_d.out_valid && lat_d < 0) lat_d = cyc;
        end
        check_val({tag, "_lat_b"}, 64'(lat_b), 64'd4);
        check_val({tag, "_lat_d"}, 64'(lat_d), 64'd16);
        check_val({tag, "_data_b"}, 64'(if_b.out_data), 64'(exp_d));
        check_val({tag, "_data_d"}, 64'(if_d.out_data), 64'(exp_d));
        check_val({tag, "_zero"}, 64'({if_b.out_zero, if_d.out_zero}), 64'({exp_z, exp_z}));
        check_val({tag, "_ovf"}, 64'({if_b.out_ovf, if_d.out_ovf}), 64'({exp_o, exp_o}));
        if_b.out_ready = 1'b1; if_d.out_ready = 1'b1;
        tick();
        if_b.out_ready = 1'b0; if_d.out_ready = 1'b0;
    endtask

    // Arithmetic reference for the 16-bit random regression.
    function automatic logic [15:0] model16(input logic [1:0] mode, input logic [15:0] x);
        logic [15:0] mag;
        mag = {1'b0, x[14:0]};
        case (mode)
            2'd0:    return 16'(-x);
            2'd1:    return x[15] ? 16'(-x) : x;
            2'd2:    return x;
            default: return x[15] ? 16'(-mag) : mag;
        endcase
    endfunction

    initial begin
        logic [63:0] held;
        logic        saw_valid;
        int          lat;

        if_a.in_valid = 0; if_a.in_data = '0; if_a.in_mode = 0; if_a.out_ready = 0;
        if_b.in_valid = 0; if_b.in_data = '0; if_b.in_mode = 0; if_b.out_ready = 0;
        if_c.in_valid = 0; if_c.in_data = '0; if_c.in_mode = 0; if_c.out_ready = 0;
        if_d.in_valid = 0; if_d.in_data = '0; if_d.in_mode = 0; if_d.out_ready = 0;

        #3;
        check_val("rst_in_ready", 64'(if_a.in_ready), 64'd1);
        check_val("rst_out_valid", 64'(if_a.out_valid), 64'd0);
        check_val("rst_out_data", if_a.out_data, 64'd0);
        check_val("rst_flags", 64'({if_a.out_zero, if_a.out_ovf}), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // NEG on 64/8
        run_a("neg_one",  2'd0, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_a("neg_zero", 2'd0, 64'h0,                   64'h0,                   1'b1, 1'b0);
        run_a("neg_min",  2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_a("neg_hi32", 2'd0, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0);
        run_a("abs_min",  2'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_a("pass_min", 2'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);

        // ABS / PASS / SM2TC on 16-bit units
        run_16("abs_neg",    2'd1, 16'hFFF6, 16'h000A, 1'b0, 1'b0);
        run_16("abs_pos",    2'd1, 16'h0005, 16'h0005, 1'b0, 1'b0);
        run_16("pass",       2'd2, 16'h8001, 16'h8001, 1'b0, 1'b0);
        run_16("sm2tc_neg",  2'd3, 16'h8005, 16'hFFFB, 1'b0, 1'b0);
        run_16("sm2tc_nz",   2'd3, 16'h8000, 16'h0000, 1'b1, 1'b0);
        run_16("neg16_min",  2'd0, 16'h8000, 16'h8000, 1'b0, 1'b1);

        // CHUNK == WIDTH: single busy cycle
        if_c.in_data = 32'h0000_0010; if_c.in_mode = 2'd0; if_c.in_valid = 1'b1;
        tick();
        if_c.in_valid = 1'b0;
        check_val("c32_busy", 64'(if_c.out_valid), 64'd0);
        tick();
        check_val("c32_valid", 64'(if_c.out_valid), 64'd1);
        check_val("c32_data", 64'(if_c.out_data), 64'h0000_0000_FFFF_FFF0);
        if_c.out_ready = 1'b1;
        tick();
        if_c.out_ready = 1'b0;

        // Back-pressure with a new operand pending
        if_a.in_data = 64'd5; if_a.in_mode = 2'd0; if_a.in_valid = 1'b1;
        tick();
        if_a.in_data = 64'd7;
        lat = 0;
        while (!if_a.out_valid && lat < 200) begin tick(); lat++; end
        check_val("bp_valid", 64'(if_a.out_valid), 64'd1);
        held = if_a.out_data;
        check_val("bp_data", held, 64'hFFFF_FFFF_FFFF_FFFB);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_hold", if_a.out_data, 64'hFFFF_FFFF_FFFF_FFFB);
            check_val("bp_busy", 64'({if_a.in_ready, if_a.out_valid}), 64'b01);
        end
        if_a.out_ready = 1'b1;
        tick();
        if_a.out_ready = 1'b0;
        check_val("bp_free", 64'({if_a.in_ready, if_a.out_valid}), 64'b10);
        tick();
        if_a.in_valid = 1'b0;
        check_val("bp_accept", 64'(if_a.in_ready), 64'd0);
        lat = 0;
        while (!if_a.out_valid && lat < 200) begin tick(); lat++; end
        check_val("bp2_lat", 64'(lat), 64'd8);
        check_val("bp2_data", if_a.out_data, 64'hFFFF_FFFF_FFFF_FFF9);
        if_a.out_ready = 1'b1;
        tick();
        if_a.out_ready = 1'b0;

        // Reset in the middle of BUSY (counter at 3)
        if_a.in_data = 64'd1; if_a.in_mode = 2'd0; if_a.in_valid = 1'b1;
        tick();
        if_a.in_valid = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check_val("arst_in_ready", 64'(if_a.in_ready), 64'd1);
        check_val("arst_out_valid", 64'(if_a.out_valid), 64'd0);
        check_val("arst_out_data", if_a.out_data, 64'd0);
        check_val("arst_flags", 64'({if_a.out_zero, if_a.out_ovf}), 64'd0);
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            saw_valid |= if_a.out_valid;
        end
        check_val("arst_no_valid", 64'(saw_valid), 64'd0);

        // Random regression against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [15:0] x, r;
            logic [1:0]  m;
            x = 16'($urandom);
            if (i % 10 == 0) x = 16'h8000;
            if (i % 10 == 5) x = 16'h0000;
            m = 2'($urandom_range(0, 3));
            r = model16(m, x);
            run_16($sformatf("rnd%0d", i), m, x, r, (r == 16'h0),
                   (m <= 2'd1) && (x == 16'h8000));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/complement_seq.md
# complement_seq

Parametrised, multi-mode two's-complement unit that processes its operand CHUNK bits per cycle, LSB first. A single "seen-one" flag carries the ripple from chunk to chunk, using the rule out[i] = in[i] XOR (OR of in[i-1:0]). The unit serves ALU and M-extension datapaths that need negate, absolute value or sign-magnitude conversion without a full-width carry chain in one cycle. Both sides use a valid/ready handshake. Results carry zero and overflow flags.

## Interface
- WIDTH, 64, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per busy cycle; 1 <= CHUNK <= WIDTH.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand offered.
- in_ready  output  1  unit can accept an operand.
- in_data  input  WIDTH  operand.
- in_mode  input  2  0 NEG, 1 ABS, 2 PASS, 3 SM2TC.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- out_data  output  WIDTH  result.
- out_zero  output  1  out_data == 0.
- out_ovf  output  1  result not representable (see Operation).

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch the operand and mode, clear the seen-one flag, set the chunk counter to 0, go to BUSY.
- Latched operand by mode:
  - SM2TC: bit WIDTH-1 is cleared before processing; the original sign is kept as neg_req.
  - All other modes: the operand is latched unchanged.
- neg decision, fixed at accept:
  - NEG: always 1.
  - ABS: in_data[WIDTH-1].
  - PASS: 0.
  - SM2TC: in_data[WIDTH-1].
- BUSY, per cycle, for chunk k = counter, bits [k*CHUNK +: CHUNK]:
  - If neg: out bit i = x[i] XOR s_i. s_i = seen-one flag OR any lower bit of x within the chunk.
  - If not neg: bits pass through unchanged.
  - The seen-one flag updates to (flag OR any bit in the chunk), regardless of neg.
  - Result bits are written into an internal result register.
  - Counter increments.
  - After chunk WIDTH/CHUNK-1, go to DONE.
- DONE:
  - out_valid=1.
  - out_data, out_zero and out_ovf are stable until out_valid & out_ready; then go to IDLE.
- out_zero = 1 iff the final seen-one flag is 0, i.e. the processed operand was all zeros.
- out_ovf:
  - 1 for NEG or ABS with operand = 1 followed by WIDTH-1 zeros (the result equals the operand).
  - 0 otherwise, including SM2TC with negative zero (result 0, out_zero=1).
- in_ready=0 in BUSY and DONE. Operands offered then are not accepted and must be held by the source.
- Mid-operation mode or data changes on the inputs have no effect; only the latched copies are used.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_zero=0, out_ovf=0, state IDLE, counter 0, seen-one flag 0.
- Asserting rst in any state aborts the operation immediately (asynchronous). The pending result is discarded; no out_valid pulse follows.
- Accept at edge t0. BUSY occupies edges t0+1..t0+N, where N = WIDTH/CHUNK. out_valid rises after edge t0+N.
- Result consumed at edge t1 (out_valid & out_ready): in_ready=1 after t1. The next accept is possible at edge t1+1.
- Minimum issue interval: N+2 cycles with out_ready tied high.
- CHUNK = WIDTH: a single BUSY cycle; latency 1 cycle to out_valid.
- out_valid held with out_ready low: out_data, out_zero and out_ovf must not change.
- Outputs are registered; no combinational path from in_* to out_*.

## Test plan
- NEG, WIDTH=64, CHUNK=8: in 0x0000_0000_0000_0001 -> out 0xFFFF_FFFF_FFFF_FFFF, zero=0, ovf=0; out_valid exactly 8 cycles after accept.
- NEG boundaries, WIDTH=64:
  - 0 -> 0, zero=1, ovf=0.
  - 0x8000_0000_0000_0000 -> same value, ovf=1.
  - 0x0000_0001_0000_0000 -> 0xFFFF_FFFF_0000_0000; checks chunk-to-chunk seen-one propagation.
- ABS / PASS / SM2TC, WIDTH=16, CHUNK=4:
  - ABS 0xFFF6 -> 0x000A.
  - ABS 0x0005 -> 0x0005.
  - PASS 0x8001 -> 0x8001.
  - SM2TC 0x8005 -> 0xFFFB.
  - SM2TC 0x8000 -> 0x0000, zero=1, ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE, with a new in_valid pending -> out_data stable, in_ready=0. After out_ready: the new operand is accepted 1 cycle later.
- Reset mid-BUSY (counter=3, WIDTH=64, CHUNK=8): rst asserted asynchronously -> all outputs at reset values immediately; no out_valid afterwards.
- CHUNK=WIDTH=32: NEG 0x0000_0010 -> 0xFFFF_FFF0, out_valid 1 cycle after accept.
- Random regression: compare against -x, |x| and the sign-magnitude model for all modes, with random CHUNK values dividing WIDTH.
